// File: rtl/auction_bid_collector_pkg.sv
// Shared widths, bid/bidder types and collector state encoding for the
// auction bid collector and the argmax10 winner selector it feeds.
package auction_pkg;

    localparam int NUM_BIDDERS = 10;
    localparam int BID_W       = 17;
    localparam int ID_W        = 4;

    typedef logic [BID_W-1:0] bid_t;
    typedef logic [ID_W-1:0]  bidder_id_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        AWARD   = 2'd2
    } collector_state_t;

endpackage

// File: rtl/auction_bid_collector_if.sv
// Bid intake and award handshakes between bidders/award consumer and the
// collector. The collector uses the slave modport, the environment the master.
interface auction_bid_collector_if
    import auction_pkg::*;
();

    logic       bid_valid;
    logic       bid_ready;
    bidder_id_t bid_id;
    bid_t       bid_value;

    logic       award_valid;
    logic       award_ready;
    bidder_id_t award_id;
    bid_t       award_value;

    modport master (
        output bid_valid, bid_id, bid_value, award_ready,
        input  bid_ready, award_valid, award_id, award_value
    );

    modport slave (
        input  bid_valid, bid_id, bid_value, award_ready,
        output bid_ready, award_valid, award_id, award_value
    );

endinterface

// File: rtl/auction_bid_collector.sv
// Bidder-side front end for argmax10: collects one bid per bidder into a
// registered vector, holds it while argmax10 evaluates, then issues one award.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting bids; timer runs once the first bid is stored
// EVAL    | bid vector frozen and presented to argmax10
// AWARD   | winner registered, waiting for award_ready
module auction_bid_collector
    import auction_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int EVAL_CYC    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    auction_bid_collector_if.slave       bus,
    output bid_t [NUM_BIDDERS-1:0]       bids,
    output logic                         bids_valid,
    input  bidder_id_t                   winner,
    output logic [7:0]                   round_count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int EW = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

    collector_state_t       state, state_nxt;
    bid_t [NUM_BIDDERS-1:0] bids_r;
    logic [NUM_BIDDERS-1:0] mask, mask_nxt, slot_hit;
    logic [TW-1:0]          timer;
    logic [EW-1:0]          eval_cnt;
    logic                   bid_ready_r, bids_valid_r, award_valid_r;
    bidder_id_t             award_id_r;
    bid_t                   award_value_r;
    logic [7:0]             round_cnt_r;
    logic                   accept, store, timeout;
    bid_t                   win_value;

    assign accept  = bus.bid_valid && bid_ready_r;
    assign timeout = (timer == TW'(TIMEOUT_CYC));

    // Decode the offered id into a one-hot slot select; out-of-range ids hit nothing.
    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (bus.bid_id == ID_W'(i)) slot_hit[i] = 1'b1;
        end
    end

    // Only the first bid from each in-range bidder is stored.
    always_comb begin
        store    = accept && |(slot_hit & ~mask);
        mask_nxt = store ? (mask | slot_hit) : mask;
    end

    // Winner lookup; an index past the last slot yields a zero award value.
    always_comb begin
        win_value = '0;
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (winner == ID_W'(i)) win_value = bids_r[i];
        end
    end

    // Next-state selection; a full mask leaves COLLECT on the same edge as the last bid.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (&mask_nxt || timeout) state_nxt = EVAL;
            EVAL:    if (eval_cnt == '0)       state_nxt = AWARD;
            AWARD:   if (bus.award_ready)      state_nxt = COLLECT;
            default:                           state_nxt = COLLECT;
        endcase
    end

    // State, handshake flags, bid vector, mask, timer, eval counter and award registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            bid_ready_r   <= 1'b0;
            bids_valid_r  <= 1'b0;
            award_valid_r <= 1'b0;
            bids_r        <= '0;
            mask          <= '0;
            timer         <= '0;
            eval_cnt      <= '0;
            award_id_r    <= '0;
            award_value_r <= '0;
            round_cnt_r   <= '0;
        end else begin
            state         <= state_nxt;
            bid_ready_r   <= (state_nxt == COLLECT);
            bids_valid_r  <= (state_nxt == EVAL);
            award_valid_r <= (state_nxt == AWARD);
            case (state)
                COLLECT: begin
                    for (int i = 0; i < NUM_BIDDERS; i++) begin
                        if (store && slot_hit[i]) bids_r[i] <= bus.bid_value;
                    end
                    mask <= mask_nxt;
                    if (state_nxt == COLLECT) begin
                        if (timer != '0)  timer <= timer + 1'b1;
                        else if (store)   timer <= TW'(1);
                    end else begin
                        eval_cnt <= EW'(EVAL_CYC - 1);
                    end
                end
                EVAL: begin
                    if (eval_cnt == '0) begin
                        award_id_r    <= winner;
                        award_value_r <= win_value;
                    end else begin
                        eval_cnt <= eval_cnt - 1'b1;
                    end
                end
                AWARD: begin
                    if (bus.award_ready) begin
                        bids_r      <= '0;
                        mask        <= '0;
                        timer       <= '0;
                        round_cnt_r <= round_cnt_r + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bid_ready   = bid_ready_r;
    assign bus.award_valid = award_valid_r;
    assign bus.award_id    = award_id_r;
    assign bus.award_value = award_value_r;
    assign bids            = bids_r;
    assign bids_valid      = bids_valid_r;
    assign round_count     = round_cnt_r;

endmodule

// File: tb/tb_auction_bid_collector.sv
// Directed bench for auction_bid_collector with a small argmax10 stand-in.
module tb_auction_bid_collector
    import auction_pkg::*;
();

    logic                   clk;
    logic                   rst;
    bid_t [NUM_BIDDERS-1:0] bids;
    logic                   bids_valid;
    bidder_id_t             winner;
    logic [7:0]             round_count;
    logic                   ovr_en;
    bidder_id_t             ovr_id;
    bidder_id_t             stub_win;
    bid_t                   stub_best;
    int                     total;
    int                     bad;

    auction_bid_collector_if bus();

    auction_bid_collector #(.TIMEOUT_CYC(64), .EVAL_CYC(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .bids        (bids),
        .bids_valid  (bids_valid),
        .winner      (winner),
        .round_count (round_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // argmax10 stand-in: highest bid, lowest index on ties, optional forced index.
    always_comb begin
        stub_win  = '0;
        stub_best = bids[0];
        for (int i = 1; i < NUM_BIDDERS; i++) begin
            if (bids[i] > stub_best) begin
                stub_best = bids[i];
                stub_win  = ID_W'(i);
            end
        end
        winner = ovr_en ? ovr_id : stub_win;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bid(input int id, input int val);
        int n;
        n = 0;
        bus.bid_valid = 1'b1;
        bus.bid_id    = ID_W'(id);
        bus.bid_value = BID_W'(val);
        while (!bus.bid_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("bid_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.bid_valid = 1'b0;
    endtask

    task automatic wait_award();
        int n;
        n = 0;
        while (!bus.award_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("award_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ovr_en = 1'b0;
        ovr_id = '0;
        bus.bid_valid   = 1'b0;
        bus.bid_id      = '0;
        bus.bid_value   = '0;
        bus.award_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("rst_bids",        bids,            0);
        chk("rst_bid_ready",   bus.bid_ready,   0);
        chk("rst_bids_valid",  bids_valid,      0);
        chk("rst_award_valid", bus.award_valid, 0);
        chk("rst_award_id",    bus.award_id,    0);
        chk("rst_award_value", bus.award_value, 0);
        chk("rst_round_count", round_count,     0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_bid_ready", bus.bid_ready, 1);

        // Full round: bidders 0..9 bid 10..100.
        for (int i = 0; i < NUM_BIDDERS; i++) send_bid(i, (i + 1) * 10);
        chk("full_bids_valid",  bids_valid,    1);
        chk("full_bid_ready",   bus.bid_ready, 0);
        chk("full_bids0",       bids[0],       10);
        chk("full_bids9",       bids[9],       100);
        @(posedge clk); #1;
        chk("full_award_valid", bus.award_valid, 1);
        chk("full_bids_valid2", bids_valid,      0);
        chk("full_award_id",    bus.award_id,    9);
        chk("full_award_value", bus.award_value, 100);
        @(posedge clk); #1;
        chk("full_award_drop",  bus.award_valid, 0);
        chk("full_round_count", round_count,     1);
        chk("full_bid_ready2",  bus.bid_ready,   1);
        chk("full_bids_clear",  bids,            0);

        // Partial round forced by timeout.
        send_bid(3, 500);
        chk("to_not_yet", bids_valid, 0);
        n = 0;
        while (!bids_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_cycles",      n,       64);
        chk("to_bids3",       bids[3], 500);
        chk("to_bids0",       bids[0], 0);
        chk("to_bids9",       bids[9], 0);
        wait_award();
        chk("to_award_id",    bus.award_id,    3);
        chk("to_award_value", bus.award_value, 500);
        @(posedge clk); #1;
        chk("to_round_count", round_count, 2);

        // Duplicate and out-of-range bids, then award back-pressure.
        bus.award_ready = 1'b0;
        send_bid(2, 7);
        send_bid(2, 900);
        send_bid(12, 131071);
        chk("dup_not_done", bids_valid, 0);
        for (int i = 0; i < NUM_BIDDERS; i++) begin
            if (i != 2) send_bid(i, 1);
        end
        chk("dup_bids_valid", bids_valid, 1);
        chk("dup_bids2",      bids[2],    7);
        chk("dup_bids0",      bids[0],    1);
        wait_award();
        chk("dup_award_id",    bus.award_id,    2);
        chk("dup_award_value", bus.award_value, 7);
        bus.bid_valid = 1'b1;
        bus.bid_id    = ID_W'(5);
        bus.bid_value = BID_W'(55);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_award_valid", bus.award_valid, 1);
            chk("bp_award_id",    bus.award_id,    2);
            chk("bp_award_value", bus.award_value, 7);
            chk("bp_bid_ready",   bus.bid_ready,   0);
            chk("bp_bids5",       bids[5],         1);
        end
        bus.award_ready = 1'b1;
        bus.bid_valid   = 1'b0;
        @(posedge clk); #1;
        chk("bp_award_drop",  bus.award_valid, 0);
        chk("bp_bid_ready",   bus.bid_ready,   1);
        chk("bp_round_count", round_count,     3);
        chk("bp_bids_clear",  bids,            0);

        // Winner index beyond the last slot awards value 0.
        ovr_en = 1'b1;
        ovr_id = ID_W'(12);
        send_bid(5, 77);
        wait_award();
        chk("oor_award_id",    bus.award_id,    12);
        chk("oor_award_value", bus.award_value, 0);
        @(posedge clk); #1;
        ovr_en = 1'b0;
        chk("oor_round_count", round_count, 4);

        // Reset while the vector is under evaluation.
        for (int i = 0; i < NUM_BIDDERS; i++) send_bid(i, 50 + i);
        chk("mr_bids_valid", bids_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mr_bids",        bids,            0);
        chk("mr_bids_valid2", bids_valid,      0);
        chk("mr_award_valid", bus.award_valid, 0);
        chk("mr_round_count", round_count,     0);
        chk("mr_bid_ready",   bus.bid_ready,   0);
        rst = 1'b0;
        for (int i = 0; i < NUM_BIDDERS; i++) send_bid(i, 9 - i);
        wait_award();
        chk("mr_award_id",    bus.award_id,    0);
        chk("mr_award_value", bus.award_value, 9);
        @(posedge clk); #1;
        chk("mr_round_count2", round_count, 1);

        // 256 single-bidder rounds wrap the round counter.
        do_reset();
        for (int r = 0; r < 256; r++) begin
            send_bid(r % NUM_BIDDERS, r * 3 + 1);
            wait_award();
            chk("wrap_award_id",    bus.award_id,    r % NUM_BIDDERS);
            chk("wrap_award_value", bus.award_value, r * 3 + 1);
            @(posedge clk); #1;
            if (r == 254) chk("wrap_count_255", round_count, 255);
        end
        chk("wrap_count_0", round_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/auction_bid_collector.md
Name: auction_bid_collector

Overview:
Bidder-side front end for the argmax10 winner selector. Accepts bids one at a time from up to NUM_BIDDERS bidders over a valid/ready handshake and assembles them into the registered bid vector that argmax10 consumes. Holds that vector stable during evaluation, captures the returned winner index, and issues one award per round to the downstream consumer. argmax10 is instantiated alongside this block, not inside it.

Parameters:
NUM_BIDDERS, 10, number of bid slots; also the width of the bids array.
BID_W, 17, bid value width.
ID_W, 4, bidder index width; must satisfy 2**ID_W >= NUM_BIDDERS.
TIMEOUT_CYC, 64, cycles after the first accepted bid before a partial round is forced to evaluation.
EVAL_CYC, 1, cycles the bid vector is held before the winner is sampled (>=1).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
bid_valid  in  1  a bid is offered.
bid_ready  out  1  collector can accept a bid.
bid_id  in  ID_W  index of the offering bidder.
bid_value  in  BID_W  bid amount.
bids  out  [NUM_BIDDERS-1:0][BID_W-1:0]  registered bid vector; drives argmax10.bids.
bids_valid  out  1  bids is stable and under evaluation.
winner  in  ID_W  winner index from argmax10.
award_valid  out  1  award available.
award_ready  in  1  award consumer accepts.
award_id  out  ID_W  winning bidder index.
award_value  out  BID_W  winning bid amount.
round_count  out  8  number of completed rounds; wraps.

Behaviour:
- Reset (rst high at a clock edge): state goes to COLLECT. bids are all 0. bid_ready, bids_valid and award_valid are 0. award_id, award_value, round_count, the received mask and the timer are 0. bid_ready rises in the first cycle after rst deasserts.
- Reset mid-round: everything is cleared on the next edge, any in-flight bids are discarded, and no award is issued.
- COLLECT state:
  - bid_ready is 1 and bids_valid is 0.
  - Accept occurs when bid_valid && bid_ready.
  - If bid_id < NUM_BIDDERS and the slot's mask bit is clear: write bids[bid_id] = bid_value and set the mask bit.
  - A duplicate id, or bid_id >= NUM_BIDDERS, is accepted and dropped. The first bid per bidder stands.
  - The timer starts at 1 on the first stored bid and increments each cycle while in COLLECT.
  - Go to EVAL on the edge after the mask becomes all-ones, or when the timer reaches TIMEOUT_CYC.
  - With no stored bids, stay in COLLECT indefinitely.
  - A bid accepted on the same edge the timer expires is still stored, and the round then evaluates.
- EVAL state:
  - bid_ready is 0 and bids_valid is 1; bids are not modified.
  - An EVAL_CYC down-counter runs. On its last cycle, register award_id = winner and award_value = bids[winner], then go to AWARD.
  - If winner >= NUM_BIDDERS, award_value is 0.
  - Absent bidders hold value 0. Tie-breaking belongs to argmax10.
- AWARD state:
  - bid_ready is 0, bids_valid is 0, award_valid is 1.
  - award_id and award_value are held stable until award_ready.
  - On the handshake edge:
    - clear bids, the mask and the timer;
    - round_count increments, with 255 wrapping to 0;
    - award_valid drops;
    - return to COLLECT.
  - bid_ready is 1 in the following cycle.
- Latency: last bid accepted on edge t gives bids_valid=1 in the cycle after t, and award_valid=1 in the cycle after t+EVAL_CYC. An award_ready already high accepts in the first award cycle.
- Back-pressure: award_ready held low keeps the block in AWARD indefinitely. No bids are accepted meanwhile.

Decomposition:
- Package auction_pkg holds:
  - NUM_BIDDERS, BID_W, ID_W;
  - typedef bid_t (logic [BID_W-1:0]) and bidder_id_t (logic [ID_W-1:0]);
  - enum collector_state_t {COLLECT, EVAL, AWARD}.
- No sub-module: a single FSM with mask, timer and eval counter.

Test Plan:
- Full round: bidders 0..9 bid 10,20,...,100 in order; award_ready=1 -> bids_valid 1 cycle, then award_id=9, award_value=100, round_count=1.
- Partial round and timeout: only bidder 3 bids 500 -> after 64 cycles bids_valid=1 with all others 0; award_id=3, award_value=500.
- Duplicate and out-of-range: bidder 2 bids 7 then 900; id 12 bids 131071; remaining bidders bid 1 -> bids[2]=7, id 12 dropped, award_id=2, award_value=7.
- Award back-pressure: award_ready low for 20 cycles -> award_valid stays 1 with constant award_id/award_value, bid_ready=0, and offered bids are not taken; on release the round clears and bid_ready=1 next cycle.
- Reset mid-EVAL: rst during bids_valid=1 -> next cycle all bids 0, award_valid 0, round_count 0; a fresh round completes normally.
- Round wrap: 256 back-to-back single-bidder rounds -> round_count returns to 0, with each award matching its round's bid.
